// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and FSM encoding for the register-bank dump reader,
// so the datapath and benches agree on sizes.
package regfile_dump_pkg;

    localparam int DUMP_DATA_W   = 32;
    localparam int DUMP_ADDR_W   = 5;
    localparam int DUMP_NUM_REGS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// (index, value) valid/ready stream leaving the dump reader.
// master drives the word, slave returns ready.
interface regfile_dump_reader_if #(
    parameter int DATA_W = regfile_dump_pkg::DUMP_DATA_W,
    parameter int ADDR_W = regfile_dump_pkg::DUMP_ADDR_W
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_addr, input  out_data, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register-bank entry through a spare read port and streams (index, value).
// Latency: 2 cycles per word minimum; out_ready low holds SEND with the word frozen.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W   = DUMP_DATA_W,
    parameter int ADDR_W   = DUMP_ADDR_W,
    parameter int NUM_REGS = DUMP_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    regfile_dump_reader_if.master stream,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       zero_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              valid_c;
    logic              launch;
    logic              capture;
    logic              accept;
    logic              last_word;

    // abort overrides every transition, including a start in the same cycle
    assign launch    = (state == S_IDLE) && start && !abort;
    assign capture   = (state == S_READ) && !abort;
    assign accept    = (state == S_SEND) && stream.out_ready && !abort;
    assign last_word = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_READ;
            end
            S_READ: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                valid_c = 1'b1;
                if (stream.out_ready) state_nxt = last_word ? S_DONE : S_READ;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (launch) begin
            idx <= '0;
        end else if (accept && !last_word) begin
            idx <= idx + 1'b1;
        end
    end

    // partial count survives abort so a debug capture can still read it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_cnt <= '0;
        end else if (launch) begin
            zero_cnt <= '0;
        end else if (capture && (rd_data == '0)) begin
            zero_cnt <= zero_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_addr_q <= '0;
            out_data_q <= '0;
        end else if (capture) begin
            out_addr_q <= idx;
            out_data_q <= rd_data;
        end
    end

    assign rd_addr         = idx;
    assign stream.out_valid = valid_c;
    assign stream.out_addr  = out_addr_q;
    assign stream.out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a scoreboard queue filled at dump launch,
// drained by a negedge monitor on every accepted word.
module tb_regfile_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   zero_cnt;

    logic [DW-1:0] bank [NR];
    exp_t          q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_mark = 0;
    int done_cnt = 0;
    int done_lat = 0;

    logic          prev_stall = 1'b0;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;

    regfile_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .stream   (sif),
        .busy     (busy),
        .done     (done),
        .zero_cnt (zero_cnt)
    );

    always #5 clk = ~clk;

    assign rd_data = bank[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every handshake, tracks done pulses and stall stability
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (start && !busy && !abort && !reset) start_mark = cyc;
        if (done) begin
            done_cnt++;
            done_lat = cyc - start_mark;
        end
        if (sif.out_valid && sif.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word", {27'd0, sif.out_addr, sif.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("word", {27'd0, sif.out_addr, sif.out_data}, {27'd0, e.a, e.d});
            end
        end
        if (prev_stall && sif.out_valid)
            chk("stall_stable", {27'd0, sif.out_addr, sif.out_data}, {27'd0, held_a, held_d});
        prev_stall = sif.out_valid && !sif.out_ready;
        held_a     = sif.out_addr;
        held_d     = sif.out_data;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_addr"},   64'(rd_addr),       64'd0);
        chk({tag, "_out_valid"}, 64'(sif.out_valid), 64'd0);
        chk({tag, "_out_addr"},  64'(sif.out_addr),  64'd0);
        chk({tag, "_out_data"},  64'(sif.out_data),  64'd0);
        chk({tag, "_busy"},      64'(busy),          64'd0);
        chk({tag, "_done"},      64'(done),          64'd0);
        chk({tag, "_zero_cnt"},  64'(zero_cnt),      64'd0);
    endtask

    // mode: 0 ready high, 1 ready 1-0-0-1, 2 re-start at word 5, 3 abort at word 10, 4 reset at word 7
    task automatic run(input int mode, input int nexp);
        int base_done;
        int pat;
        bit fin;
        bit sent;
        logic [3:0] ready_pat;
        ready_pat = 4'b1001;
        base_done = done_cnt;
        pat  = 0;
        fin  = 1'b0;
        sent = 1'b0;
        for (int i = 0; i < nexp; i++) q.push_back({AW'(i), bank[i]});
        @(posedge clk); #1;
        start = 1'b1;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (mode == 1) begin
                sif.out_ready = ready_pat[3 - (pat % 4)];
                pat++;
            end
            if (mode == 2) begin
                start = (!sent && sif.out_valid && sif.out_addr == 5);
                if (start) sent = 1'b1;
            end
            if (mode == 3 && sif.out_valid && sif.out_addr == 10) begin
                sif.out_ready = 1'b0;
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_out_valid", 64'(sif.out_valid), 64'd0);
                chk("abort_busy",      64'(busy),          64'd0);
                chk("abort_done",      64'(done),          64'd0);
                chk("abort_zero_cnt",  64'(zero_cnt),      64'd1);
                fin = 1'b1;
            end else if (mode == 4 && sif.out_valid && sif.out_addr == 7) begin
                sif.out_ready = 1'b0;
                #2 reset = 1'b1;
                #1 check_reset_vals("midreset");
                @(posedge clk); @(posedge clk); #1;
                reset = 1'b0;
                sif.out_ready = 1'b1;
                begin
                    bit seen;
                    seen = 1'b0;
                    for (int k = 0; k < 12; k++) begin
                        @(posedge clk); #1;
                        if (sif.out_valid || busy) seen = 1'b1;
                    end
                    chk("post_reset_idle", 64'(seen), 64'd0);
                end
                fin = 1'b1;
            end else if (done_cnt != base_done) begin
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL timeout mode=%0d actual=no_done required=done", mode);
        end
        sif.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt - base_done), (mode >= 3) ? 64'd0 : 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
        if (mode == 0) chk("done_latency", 64'(done_lat), 64'd65);
        q.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < NR; i++) bank[i] = DW'(i);
        #12;
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // bank[i] = i, ready high: 32 words, one zero
        run(0, NR);
        chk("t1_zero_cnt", 64'(zero_cnt), 64'd1);

        // ready 1-0-0-1 pattern, same contents
        run(1, NR);
        chk("t2_zero_cnt", 64'(zero_cnt), 64'd1);

        // all-zero bank
        for (int i = 0; i < NR; i++) bank[i] = '0;
        run(0, NR);
        chk("t3_zero_cnt", 64'(zero_cnt), 64'd32);

        // distinct values with two holes so data must come from the read port
        for (int i = 0; i < NR; i++) bank[i] = 32'hDEAD_0000 ^ (32'h0101_0101 * i);
        bank[3]  = '0;
        bank[17] = '0;
        run(1, NR);
        chk("t3b_zero_cnt", 64'(zero_cnt), 64'd2);

        // second start mid-dump is ignored
        for (int i = 0; i < NR; i++) bank[i] = DW'(i);
        run(2, NR);
        chk("t4_zero_cnt", 64'(zero_cnt), 64'd1);

        // abort during word 10, then a fresh dump restarts at index 0
        run(3, 10);
        run(0, NR);

        // asynchronous reset during word 7
        run(4, 7);
        run(0, NR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
